simd_scan_unit: RTL and testbench

- Parametrised, fully pipelined SIMD scan (prefix) unit for the custom-instruction path of the vector core.
- Successor of the fixed 8x32-bit prefix-sum unit: generic lane count and width, selectable operator (add/max/min), inclusive/exclusive mode, and an explicit per-vector stream-restart flag.
- Carries the running total across consecutive vectors so long arrays are scanned one vector per cycle; destination tag travels with the data.

---
 rtl/simd_scan_unit.sv | 194 +++++++++++++++++++
 tb/tb_simd_scan_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/simd_scan_unit.sv
`default_nettype none
// ============================================================================
// Module      : simd_scan_unit
// Description : Fully pipelined SIMD scan (prefix) unit. A Kogge-Stone
//               network of STG = log2(LANES) register stages computes the
//               per-vector prefix, then a carry stage folds in the running
//               total from previous vectors. Operators: add, unsigned max,
//               unsigned min. Inclusive or exclusive scan, per-vector
//               stream restart (in_clr). Latency STG+1, one vector/cycle.
//
//               Optional macro SCAN_SAT_EN: add saturates at 2^DATA_W-1
//               instead of wrapping (network and carry stage).
//
// Ports       : clk, reset (sync, active-high)
//               in_v/in_data/in_tag/in_op/in_excl/in_clr : input vector
//               out_v/out_data/out_tag/out_total         : scanned result
//               Lane i of in_data/out_data is [DATA_W*(i+1)-1 -: DATA_W].
// Revision    : 1.0 - initial release
// ============================================================================
module simd_scan_unit #(
    parameter int LANES  = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_v,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [1:0]              in_op,
    input  logic                    in_excl,
    input  logic                    in_clr,
    output logic                    out_v,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic [DATA_W-1:0]       out_total
);

    localparam int STG = $clog2(LANES);

    typedef logic [DATA_W-1:0] lane_t;

    // Lane combine under the selected operator; 2'b11 behaves as add.
    function automatic lane_t scan_op(input lane_t a, input lane_t b, input logic [1:0] op);
        lane_t r;
`ifdef SCAN_SAT_EN
        logic [DATA_W:0] sum;
`endif
        case (op)
            2'b01:   r = (a > b) ? a : b;
            2'b10:   r = (a < b) ? a : b;
            default: begin
`ifdef SCAN_SAT_EN
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
                r   = a + b;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic lane_t identity(input logic [1:0] op);
        return (op == 2'b10) ? '1 : '0;
    endfunction

    // ------------------------------------------------------------------
    // Network stage registers (index s holds the result of network stage s+1)
    // ------------------------------------------------------------------
    lane_t            stg_data [STG][LANES];
    logic [STG-1:0]   stg_v;
    logic [STG-1:0]   stg_excl;
    logic [STG-1:0]   stg_clr;
    logic [1:0]       stg_op   [STG];
    logic [TAG_W-1:0] stg_tag  [STG];

    // Inputs feeding each network stage (stage 0 is fed by the ports)
    lane_t            src      [STG][LANES];
    logic [STG-1:0]   src_v;
    logic [STG-1:0]   src_excl;
    logic [STG-1:0]   src_clr;
    logic [1:0]       src_op   [STG];
    logic [TAG_W-1:0] src_tag  [STG];
    lane_t            nxt      [STG][LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            src[0][i] = in_data[DATA_W*i +: DATA_W];
        end
        src_v[0]    = in_v;
        src_excl[0] = in_excl;
        src_clr[0]  = in_clr;
        src_op[0]   = in_op;
        src_tag[0]  = in_tag;
        for (int s = 1; s < STG; s++) begin
            for (int i = 0; i < LANES; i++) begin
                src[s][i] = stg_data[s-1][i];
            end
            src_v[s]    = stg_v[s-1];
            src_excl[s] = stg_excl[s-1];
            src_clr[s]  = stg_clr[s-1];
            src_op[s]   = stg_op[s-1];
            src_tag[s]  = stg_tag[s-1];
        end
    end

    // Stage s combines each lane with the lane 2^s below it; lower lanes pass.
    always_comb begin
        for (int s = 0; s < STG; s++) begin
            for (int i = 0; i < LANES; i++) begin
                int d;
                int j;
                d = 1 << s;
                j = (i >= d) ? (i - d) : i;
                nxt[s][i] = (i >= d) ? scan_op(src[s][i], src[s][j], src_op[s]) : src[s][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_v    <= '0;
            stg_excl <= '0;
            stg_clr  <= '0;
            for (int s = 0; s < STG; s++) begin
                stg_op[s]  <= '0;
                stg_tag[s] <= '0;
                for (int i = 0; i < LANES; i++) begin
                    stg_data[s][i] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < STG; s++) begin
                stg_v[s] <= src_v[s];
                if (src_v[s]) begin
                    stg_excl[s] <= src_excl[s];
                    stg_clr[s]  <= src_clr[s];
                    stg_op[s]   <= src_op[s];
                    stg_tag[s]  <= src_tag[s];
                    for (int i = 0; i < LANES; i++) begin
                        stg_data[s][i] <= nxt[s][i];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Carry stage. out_total is the carry register: it is exactly the
    // running reduction after the last valid vector, and both reset to 0.
    // Forwarding it back here keeps back-to-back vectors gap-free.
    // ------------------------------------------------------------------
    logic [1:0]              c_op;
    lane_t                   carry_in;
    lane_t                   incl     [LANES];
    logic [LANES*DATA_W-1:0] res_data;

    always_comb begin
        c_op     = stg_op[STG-1];
        carry_in = stg_clr[STG-1] ? identity(c_op) : out_total;
        for (int i = 0; i < LANES; i++) begin
            incl[i] = scan_op(carry_in, stg_data[STG-1][i], c_op);
        end
        res_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!stg_excl[STG-1]) begin
                res_data[DATA_W*i +: DATA_W] = incl[i];
            end else if (i == 0) begin
                res_data[DATA_W*i +: DATA_W] = carry_in;
            end else begin
                res_data[DATA_W*i +: DATA_W] = incl[(i == 0) ? 0 : i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_v     <= 1'b0;
            out_data  <= '0;
            out_total <= '0;
            out_tag   <= '0;
        end else begin
            out_v <= stg_v[STG-1];
            if (stg_v[STG-1]) begin
                out_data  <= res_data;
                out_total <= incl[LANES-1];
                out_tag   <= stg_tag[STG-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_scan_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_scan_unit
// Description : Self-checking bench for simd_scan_unit (LANES=8, DATA_W=32).
//               A sequential reference scan predicts each result; expected
//               outputs appear L cycles after issue and hold otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_scan_unit;

    localparam int LANES  = 8;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 3;
    localparam int L      = 4;
    localparam int W      = LANES*DATA_W;

    typedef logic [DATA_W-1:0] lane_t;

    typedef struct {
        logic             v;
        logic [W-1:0]     data;
        lane_t            total;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             in_v;
    logic [W-1:0]     in_data;
    logic [TAG_W-1:0] in_tag;
    logic [1:0]       in_op;
    logic             in_excl;
    logic             in_clr;
    logic             out_v;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    lane_t            out_total;

    simd_scan_unit #(.LANES(LANES), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_v(in_v), .in_data(in_data), .in_tag(in_tag), .in_op(in_op),
        .in_excl(in_excl), .in_clr(in_clr),
        .out_v(out_v), .out_data(out_data), .out_tag(out_tag), .out_total(out_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    exp_t             q[$];
    lane_t            carry = '0;
    logic             exp_v = 1'b0;
    logic [W-1:0]     exp_data = '0;
    lane_t            exp_total = '0;
    logic [TAG_W-1:0] exp_tag = '0;

    function automatic lane_t mop(input lane_t a, input lane_t b, input logic [1:0] op);
        logic [DATA_W:0] s;
        if (op == 2'b01) return (a > b) ? a : b;
        if (op == 2'b10) return (a < b) ? a : b;
        s = {1'b0, a} + {1'b0, b};
`ifdef SCAN_SAT_EN
        if (s > {1'b0, {DATA_W{1'b1}}}) return {DATA_W{1'b1}};
`endif
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [W-1:0] pk8(input lane_t a0, input lane_t a1, input lane_t a2,
                                         input lane_t a3, input lane_t a4, input lane_t a5,
                                         input lane_t a6, input lane_t a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, check at +1.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [TAG_W-1:0] t,
                        input logic [1:0] op, input logic ex, input logic cl, input logic rs);
        exp_t  e;
        exp_t  p;
        lane_t acc;
        lane_t x;
        @(negedge clk);
        in_v = v; in_data = d; in_tag = t; in_op = op; in_excl = ex; in_clr = cl; reset = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            carry = '0; exp_v = 1'b0; exp_data = '0; exp_total = '0; exp_tag = '0;
        end else begin
            e.v = v; e.data = '0; e.total = '0; e.tag = t;
            if (v) begin
                acc = cl ? ((op == 2'b10) ? {DATA_W{1'b1}} : '0) : carry;
                for (int i = 0; i < LANES; i++) begin
                    x = d[DATA_W*i +: DATA_W];
                    if (ex) e.data[DATA_W*i +: DATA_W] = acc;
                    acc = mop(acc, x, op);
                    if (!ex) e.data[DATA_W*i +: DATA_W] = acc;
                end
                e.total = acc;
                carry   = acc;
            end
            q.push_back(e);
            exp_v = 1'b0;
            if (q.size() >= L) begin
                p = q.pop_front();
                if (p.v) begin
                    exp_v = 1'b1; exp_data = p.data; exp_total = p.total; exp_tag = p.tag;
                end
            end
        end
        #1;
        chk("out_v", W'(out_v), W'(exp_v));
        chk("out_data", out_data, exp_data);
        chk("out_total", W'(out_total), W'(exp_total));
        chk("out_tag", W'(out_tag), W'(exp_tag));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] seq;
    logic [W-1:0] mm;
    logic [W-1:0] rd;
    lane_t        lane1;

    initial begin
        in_v = 0; in_data = '0; in_tag = '0; in_op = '0; in_excl = 0; in_clr = 0; reset = 1;
        ones = pk8(1, 1, 1, 1, 1, 1, 1, 1);
        seq  = pk8(1, 2, 3, 4, 5, 6, 7, 8);
        mm   = pk8(3, 1, 7, 2, 9, 0, 4, 8);

        // Reset state
        step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("rst_out_v", W'(out_v), '0);
        chk("rst_out_data", out_data, '0);

        // Inclusive add chain: restart, continue, restart
        step(1'b1, seq, 3'd5, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b1, ones, 3'd1, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, ones, 3'd2, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("lat_not_early", W'(out_v), '0);
        idle(1);
        chk("incl_v", W'(out_v), W'(1'b1));
        chk("incl_data", out_data, pk8(1, 3, 6, 10, 15, 21, 28, 36));
        chk("incl_total", W'(out_total), W'(36));
        chk("incl_tag", W'(out_tag), W'(5));
        idle(1);
        chk("chain_data", out_data, pk8(37, 38, 39, 40, 41, 42, 43, 44));
        chk("chain_total", W'(out_total), W'(44));
        idle(1);
        chk("restart_data", out_data, pk8(1, 2, 3, 4, 5, 6, 7, 8));
        chk("restart_total", W'(out_total), W'(8));
        idle(1);
        chk("hold_data", out_data, pk8(1, 2, 3, 4, 5, 6, 7, 8));

        // Exclusive add
        step(1'b1, seq, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("excl_data", out_data, pk8(0, 1, 3, 6, 10, 15, 21, 28));
        chk("excl_total", W'(out_total), W'(36));

        // Max / min
        step(1'b1, mm, 3'd3, 2'b01, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("max_data", out_data, pk8(3, 3, 7, 7, 9, 9, 9, 9));
        step(1'b1, mm, 3'd4, 2'b10, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("min_data", out_data, pk8(3, 1, 1, 1, 1, 0, 0, 0));

        // Wrap / saturate boundary
        step(1'b1, pk8(32'hFFFF_FFFF, 2, 0, 0, 0, 0, 0, 0), 3'd6, 2'b00, 1'b0, 1'b1, 1'b0);
        idle(3);
        lane1 = out_data[2*DATA_W-1 -: DATA_W];
`ifdef SCAN_SAT_EN
        chk("sat_lane1", W'(lane1), W'(32'hFFFF_FFFF));
`else
        chk("wrap_lane1", W'(lane1), W'(1));
`endif

        // Reset mid-stream discards in-flight vectors
        step(1'b1, ones, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b1, ones, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, ones, 3'd3, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b1, ones, 3'd4, 2'b00, 1'b0, 1'b0, 1'b1);
        idle(4);
        chk("rst_flush_v", W'(out_v), '0);
        step(1'b1, ones, 3'd7, 2'b00, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("post_rst_data", out_data, pk8(1, 2, 3, 4, 5, 6, 7, 8));
        chk("post_rst_tag", W'(out_tag), W'(7));

        // Randomized traffic against the reference scan
        for (int n = 0; n < 400; n++) begin
            logic big;
            big = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < LANES; i++) begin
                rd[DATA_W*i +: DATA_W] = big ? $urandom() : DATA_W'($urandom_range(0, 15));
            end
            step($urandom_range(0, 3) != 0, rd, TAG_W'($urandom()), 2'($urandom()),
                 1'($urandom()), $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
        end
        idle(L);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
